// File: rtl/ofdm_rx_frame_ctrl_if.sv
// Control/handshake bundle between the frame sequencer and the receiver top level.
interface ofdm_rx_frame_ctrl_if #(
  parameter int SYM_W = 8
);
  logic             frame_start;
  logic [SYM_W-1:0] num_sym;
  logic             abort;
  logic             adc_valid;
  logic             sync_found;
  logic             rx_out_valid;
  logic             sync_en;
  logic             dp_valid;
  logic             dp_zero;
  logic             sym_start;
  logic [SYM_W-1:0] sym_idx;
  logic             busy;
  logic             frame_done;
  logic             timeout_err;

  modport master (
    output frame_start, num_sym, abort, adc_valid, sync_found, rx_out_valid,
    input  sync_en, dp_valid, dp_zero, sym_start, sym_idx, busy, frame_done, timeout_err
  );

  modport slave (
    input  frame_start, num_sym, abort, adc_valid, sync_found, rx_out_valid,
    output sync_en, dp_valid, dp_zero, sym_start, sym_idx, busy, frame_done, timeout_err
  );
endinterface

// File: rtl/ofdm_rx_frame_ctrl.sv
// Frame sequencer for the MIMO-OFDM receiver: arms sync, drops the cyclic
// prefix, gates NSYM symbols of ADC samples into the datapath, pushes the last
// symbol out with zero-valued flush samples, then waits for every demapped
// output of the frame (or a timeout). No sample data passes through here.
module ofdm_rx_frame_ctrl #(
  parameter int NFFT        = 64,
  parameter int NCP         = 16,
  parameter int FLUSH_EXTRA = 20,
  parameter int TIMEOUT     = 1024,
  parameter int SYM_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ofdm_rx_frame_ctrl_if.slave  bus
);

  localparam int FLUSH_LEN = NFFT + FLUSH_EXTRA;
  localparam int CNT_W     = $clog2(FLUSH_LEN + NCP + 1);
  localparam int TMO_W     = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SYNC,
    S_CP,
    S_DATA,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] samp_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [15:0]      out_cnt;
  logic [15:0]      out_cnt_nxt;
  logic [15:0]      out_target;
  logic [SYM_W-1:0] nsym;
  logic [SYM_W-1:0] sym_idx_r;
  logic             timeout_r;
  logic             counting;

  // Demapper outputs of early symbols arrive while later symbols are still
  // coming in, so outputs are counted from sync search through drain.
  assign out_target = 16'(nsym) * 16'(NFFT);
  assign counting   = (state == S_WAIT_SYNC) || (state == S_CP) || (state == S_DATA) ||
                      (state == S_FLUSH) || (state == S_DRAIN);

  // Saturating output count including this cycle's rx_out_valid.
  always_comb begin
    out_cnt_nxt = out_cnt;
    if (counting && bus.rx_out_valid && (out_cnt < out_target)) begin
      out_cnt_nxt = out_cnt + 16'd1;
    end
  end

  // dp_valid follows adc_valid with zero latency so it lines up with the ADC data.
  assign bus.sync_en     = (state == S_WAIT_SYNC);
  assign bus.dp_valid    = ((state == S_DATA) && bus.adc_valid) || (state == S_FLUSH);
  assign bus.dp_zero     = (state == S_FLUSH);
  assign bus.sym_start   = (state == S_DATA) && bus.adc_valid && (samp_cnt == '0);
  assign bus.sym_idx     = sym_idx_r;
  assign bus.busy        = (state != S_IDLE);
  assign bus.frame_done  = (state == S_DONE);
  assign bus.timeout_err = timeout_r;

  // Frame state machine with its sample, timeout and output counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      samp_cnt  <= '0;
      tmo_cnt   <= '0;
      out_cnt   <= '0;
      nsym      <= '0;
      sym_idx_r <= '0;
      timeout_r <= 1'b0;
    end else if (bus.abort) begin
      state     <= S_IDLE;
      samp_cnt  <= '0;
      tmo_cnt   <= '0;
      out_cnt   <= '0;
      sym_idx_r <= '0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      out_cnt   <= out_cnt_nxt;
      unique case (state)
        S_IDLE: begin
          if (bus.frame_start) begin
            nsym      <= bus.num_sym;
            out_cnt   <= '0;
            sym_idx_r <= '0;
            tmo_cnt   <= '0;
            samp_cnt  <= '0;
            state     <= (bus.num_sym != '0) ? S_WAIT_SYNC : S_DONE;
          end
        end
        S_WAIT_SYNC: begin
          if (bus.sync_found) begin
            state    <= S_CP;
            samp_cnt <= '0;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            timeout_r <= 1'b1;
            tmo_cnt   <= '0;
            state     <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_CP: begin
          if (bus.adc_valid) begin
            if (samp_cnt == CNT_W'(NCP - 1)) begin
              samp_cnt <= '0;
              state    <= S_DATA;
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (bus.adc_valid) begin
            if (samp_cnt == CNT_W'(NFFT - 1)) begin
              samp_cnt <= '0;
              if (sym_idx_r == nsym - SYM_W'(1)) begin
                state <= S_FLUSH;
              end else begin
                sym_idx_r <= sym_idx_r + 1'b1;
                state     <= S_CP;
              end
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (samp_cnt == CNT_W'(FLUSH_LEN - 1)) begin
            samp_cnt <= '0;
            tmo_cnt  <= '0;
            state    <= S_DRAIN;
          end else begin
            samp_cnt <= samp_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_cnt_nxt == out_target) begin
            state <= S_DONE;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            timeout_r <= 1'b1;
            tmo_cnt   <= '0;
            state     <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ofdm_rx_frame_ctrl.md
Name: ofdm_rx_frame_ctrl

Overview:
Frame-level sequencer for the 2x2 MIMO-OFDM receiver datapath (sync → NCO/rotator → FFT → ZF → CPE → demap).
- Arms the sync block and strips the cyclic prefix.
- Gates ADC samples into the datapath for NSYM symbols, then injects zero-valued flush samples to push the final symbol through the CPE ping-pong buffer.
- Counts demapped outputs and reports frame completion or timeout.
- Carries no sample data. The top level uses dp_valid and dp_zero to gate and mux ADC samples.

Parameters:
NFFT, 64, FFT size in samples per symbol.
NCP, 16, cyclic-prefix length in samples.
FLUSH_EXTRA, 20, zero samples injected beyond NFFT during flush.
TIMEOUT, 1024, maximum cycles allowed in WAIT_SYNC or DRAIN.
SYM_W, 8, width of the symbol count and index.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
frame_start  in  1  pulse; latches num_sym and starts a frame (accepted only in IDLE)
num_sym  in  SYM_W  number of OFDM symbols in the frame
abort  in  1  pulse; returns to IDLE from any state
adc_valid  in  1  ADC sample valid
sync_found  in  1  pulse; the next adc_valid sample is the first CP sample of symbol 0
rx_out_valid  in  1  demapper out_valid (one per subcarrier)
sync_en  out  1  enables the sync correlator
dp_valid  out  1  in_valid to the rotator/FFT chain
dp_zero  out  1  forces the datapath sample input to 0
sym_start  out  1  first DATA sample of each symbol
sym_idx  out  SYM_W  index of the current symbol
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse
timeout_err  out  1  one-cycle pulse

Behaviour:
- States: IDLE, WAIT_SYNC, CP, DATA, FLUSH, DRAIN, DONE. All state and counters are registered.
- Reset: state=IDLE, all counters=0. sync_en, dp_valid, dp_zero, sym_start, busy, frame_done and timeout_err are all 0. sym_idx=0.
- IDLE:
  - frame_start with num_sym>0 → WAIT_SYNC. Latch nsym. Clear out_cnt, sym_idx and tmo_cnt.
  - frame_start with num_sym=0 → DONE.
- WAIT_SYNC:
  - sync_en=1.
  - sync_found → CP, samp_cnt=0.
  - tmo_cnt reaches TIMEOUT-1 without sync_found → timeout_err pulse, IDLE.
- CP:
  - Each adc_valid increments samp_cnt. dp_valid=0, so CP samples are dropped.
  - When samp_cnt=NCP-1 and adc_valid are both true → DATA, samp_cnt=0.
- DATA:
  - dp_valid = adc_valid (combinational, zero latency, aligned with the ADC data).
  - sym_start = adc_valid && samp_cnt==0.
  - When samp_cnt=NFFT-1 and adc_valid are both true:
    - If sym_idx==nsym-1 → FLUSH, samp_cnt=0.
    - Otherwise sym_idx+1 → CP.
- FLUSH:
  - dp_valid=1 and dp_zero=1 every cycle, regardless of adc_valid.
  - Lasts exactly NFFT+FLUSH_EXTRA cycles, then → DRAIN with tmo_cnt=0.
- out_cnt:
  - 16 bits. Increments on rx_out_valid in WAIT_SYNC through DRAIN, because outputs of early symbols overlap the input of later symbols.
  - Saturates at nsym*NFFT. Outputs beyond that are ignored.
- DRAIN:
  - When out_cnt==nsym*NFFT, counting any rx_out_valid in the same cycle → DONE.
  - tmo_cnt reaches TIMEOUT-1 first → timeout_err, IDLE.
- DONE: frame_done=1 for one cycle, then → IDLE.
- busy is low in IDLE and high in every other state, including DONE.
- Priority: rst > abort > all other transitions.
  - abort: IDLE next cycle. No frame_done or timeout_err. Counters are cleared.
- frame_start outside IDLE is ignored.
- sync_found outside WAIT_SYNC is ignored.
- sym_idx holds its value after the frame and clears on the next accepted frame_start.

Test Plan:
- Single symbol: frame_start with num_sym=1, then sync_found, then 80 consecutive adc_valid, then 64 rx_out_valid.
  - dp_valid low for the first 16 samples and high for the next 64.
  - sym_start once, on sample 16.
  - FLUSH holds dp_valid=dp_zero=1 for exactly 84 cycles.
  - frame_done pulses one cycle after the 64th rx_out_valid counts. busy falls with it.
- Three symbols with adc_valid gaps (1 valid every 2 cycles):
  - sym_start fires 3 times with sym_idx=0,1,2.
  - 192 dp_valid samples in DATA; no CP sample ever passed.
  - frame_done after 192 outputs.
- No sync: frame_start, then sync_found held low → timeout_err exactly 1024 cycles after entering WAIT_SYNC; state returns to IDLE; frame_done stays 0.
- Drain starvation: num_sym=1, only 63 rx_out_valid → timeout_err 1024 cycles after entering DRAIN; no frame_done.
- Abort and re-trigger:
  - abort mid-DATA → dp_valid=0 and busy=0 next cycle.
  - A frame_start issued during DATA before the abort is ignored.
  - A new frame after the abort completes normally.
- Edge cases:
  - num_sym=0 → frame_done one cycle after frame_start; no dp_valid.
  - 70 rx_out_valid on num_sym=1 → out_cnt saturates at 64.
  - Synchronous rst mid-FLUSH → all outputs 0 next cycle.
